// File: rtl/dmem_responder.sv
// Data-memory responder for a processor load/store stage.
// Accepts one request at a time, waits LATENCY cycles, then returns a
// single-cycle response carrying extended load data or a store ack.
// Storage is a little-endian word array. It is not cleared by reset.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic        Wr,
   input  logic [31:0] Address,
   input  logic [2:0]  DMCtrl,
   input  logic [31:0] DataWr,
   output logic        Ready,
   output logic        RspValid,
   output logic [31:0] DataRd,
   output logic        Err
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          enter_resp;
   logic          cur_wr;
   logic [31:0]   cur_addr;
   logic [2:0]    cur_ctrl;
   logic [31:0]   cur_wdata;
   logic          cur_err;
   logic [IW-1:0] idx;
   logic [31:0]   old_word, new_word, shifted, wr_shift, load_val;
   logic [3:0]    wmask;
   logic          mem_we;

   // State, counter, captured request and response registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         ctrl_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         ctrl_q  <= ctrl_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Next state: WAIT lasts LATENCY cycles. LATENCY=0 jumps straight to RESP.
   // enter_resp marks the edge where the access is performed.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Req) begin
               if (LATENCY == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d    = S_RESP;
               cnt_d      = '0;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: handshake from state, data/err held from the last response
   always_comb begin
      Ready    = (state_q == S_IDLE);
      RspValid = (state_q == S_RESP);
      DataRd   = data_q;
      Err      = err_q;
   end

   // Request capture. In IDLE the live inputs are the current request, so a
   // zero-latency access can complete on the accept edge itself.
   always_comb begin
      wr_d    = wr_q;
      addr_d  = addr_q;
      ctrl_d  = ctrl_q;
      wdata_d = wdata_q;
      if (state_q == S_IDLE && Req) begin
         wr_d    = Wr;
         addr_d  = Address;
         ctrl_d  = DMCtrl;
         wdata_d = DataWr;
      end
      if (state_q == S_IDLE) begin
         cur_wr    = Wr;
         cur_addr  = Address;
         cur_ctrl  = DMCtrl;
         cur_wdata = DataWr;
      end else begin
         cur_wr    = wr_q;
         cur_addr  = addr_q;
         cur_ctrl  = ctrl_q;
         cur_wdata = wdata_q;
      end
   end

   // Access decode: error check, load extraction, and store byte merge
   always_comb begin
      cur_err = 1'b0;
      case (cur_ctrl)
         3'b000, 3'b100: cur_err = 1'b0;
         3'b001, 3'b101: cur_err = cur_addr[0];
         3'b010:         cur_err = (cur_addr[1:0] != 2'b00);
         default:        cur_err = 1'b1;
      endcase
      if (cur_addr[31:2] >= 30'(DEPTH_WORDS)) cur_err = 1'b1;
      // Unsigned variants have no meaning for stores.
      if (cur_wr && cur_ctrl[2]) cur_err = 1'b1;

      idx      = cur_addr[IW+1:2];
      old_word = mem[idx];
      shifted  = old_word >> {cur_addr[1:0], 3'b000};
      case (cur_ctrl[1:0])
         2'b00:   load_val = cur_ctrl[2] ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = cur_ctrl[2] ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         default: load_val = old_word;
      endcase

      case (cur_ctrl[1:0])
         2'b00:   wmask = 4'b0001 << cur_addr[1:0];
         2'b01:   wmask = 4'b0011 << cur_addr[1:0];
         default: wmask = 4'b1111;
      endcase
      wr_shift = cur_wdata << {cur_addr[1:0], 3'b000};
      new_word = old_word;
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) new_word[8*b +: 8] = wr_shift[8*b +: 8];
      end

      mem_we = enter_resp && cur_wr && !cur_err;
      data_d = data_q;
      err_d  = err_q;
      if (enter_resp) begin
         err_d  = cur_err;
         data_d = (cur_err || cur_wr) ? 32'h0 : load_val;
      end
   end

   // Storage write. No reset, so contents survive a reset.
   always_ff @(posedge Clk) begin
      if (mem_we) mem[idx] <= new_word;
   end

endmodule
